pipelined_add_sub: RTL and testbench
====================================

// Module: pipelined_add_sub
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor for the CPU datapath ALU.
//  Carry chain split into SEG_WIDTH-bit segments, one register stage per segment:
//  one operation accepted per clock, result after STAGES cycles.
//  Supports add, subtract, add-with-carry, subtract-with-borrow; reports NZCV flags.
//  valid/ready handshake on both sides; full back-pressure, no loss, in-order results.
// PARAMETERS
//  WIDTH      32  operand/result width in bits; must be a multiple of SEG_WIDTH
//  SEG_WIDTH   8  bits resolved per pipeline stage; STAGES = WIDTH/SEG_WIDTH (>=1)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operand set valid
//  in_ready   out  1      block can accept operands this cycle
//  op         in   2      00 ADD a+b, 01 SUB a-b, 10 ADC a+b+cin, 11 SBC a+~b+cin
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in (used by ADC/SBC only; ignored for ADD/SUB)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result this cycle
//  result     out  WIDTH  sum/difference, modulo 2^WIDTH
//  flag_n     out  1      result[WIDTH-1]
//  flag_z     out  1      result == 0
//  flag_c     out  1      carry out of MSB (SUB/SBC: 1 = no borrow)
//  flag_v     out  1      signed overflow
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all stage valid bits, out_valid, result, flags -> 0;
//    in-flight operations discarded. in_ready is 1 from the first cycle after reset.
//  - Operand prep at accept: b_eff = op[0] ? ~b : b; c0 = ADD:0, SUB:1, ADC/SBC:cin.
//  - Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational).
//    Transfer in when in_valid && in_ready. All stages shift together when adv=1;
//    hold when adv=0. Bubbles (valid=0) propagate like data.
//  - Stage k (0..STAGES-1) adds segment k of a and b_eff with the carry from stage k-1
//    (stage 0: c0), registers the segment sum and carry-out. Unused upper segments of
//    a/b_eff travel forward in pipeline registers; lower sum segments are skewed forward.
//  - Latency: accepted at edge T -> out_valid=1 after edge T+STAGES-1 (visible during
//    cycle T+STAGES-1). Throughput 1/cycle while out_ready=1.
//  - Flags computed in last stage: C = final carry; V = (a[MSB]==b_eff[MSB]) &&
//    (result[MSB]!=a[MSB]); N, Z from result. Flags change only with result.
//  - result/flags hold stable while out_valid && !out_ready.
//  - Simultaneous accept and drain when full: allowed; out_ready=1 makes adv=1.
//  - Wrap-around is modular; no saturation. STAGES=1 degenerates to a registered adder.
//  - Illegal WIDTH % SEG_WIDTH != 0: elaboration-time error (generate-guarded $error).
// STRUCTURE
//  - Shared header add_sub_defs.vh: op encodings OP_ADD/OP_SUB/OP_ADC/OP_SBC, flag bit
//    indices for the ALU status register.
//  - One sub-module add_sub_stage (SEG_WIDTH, gated by adv): segment adder built from
//    the existing FA cell chain, plus valid/carry/pass-through registers.
//  - Top: operand prep, generate loop over STAGES, flag logic, handshake.
// TESTING (WIDTH=32, SEG_WIDTH=8, latency 4)
//  1. SUB a=5 b=3, out_ready=1 -> after 4 cycles result=2, C=1 V=0 N=0 Z=0.
//  2. ADD 0x7FFFFFFF+1 -> 0x80000000, V=1 N=1 C=0; ADD 0xFFFFFFFF+1 -> 0, C=1 Z=1 V=0.
//  3. 64-bit chain: ADD lo(0xFFFFFFFF+1) then ADC hi(0+0, cin=C_lo=1) -> hi=1, lo=0.
//  4. 8 back-to-back ops, out_ready low for 3 cycles mid-stream -> in_ready low in same
//     cycles, result held stable, all 8 results in order, none lost or duplicated.
//  5. rst_n=0 for 1 cycle with 3 ops in flight -> out_valid=0, result=0 next cycle;
//     no stale result emerges in following 4 cycles.
//  6. Random 10k ops, all ops, random valid/ready -> matches reference model incl. NZCV.

Source files
------------

// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined ALU adder/subtractor:
// operation encodings, ALU status-register flag positions and the
// full-adder cell that every segment carry chain is built from.
package pipelined_add_sub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,  // a + b
    OP_SUB = 2'b01,  // a - b
    OP_ADC = 2'b10,  // a + b + cin
    OP_SBC = 2'b11   // a + ~b + cin
  } op_e;

  // Bit positions of the NZCV flags inside the ALU status nibble.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/pipelined_add_sub_stage.sv
// One pipeline stage of the segmented adder. Resolves segment IDX of
// a + b_eff + carry_in with a chain of FA cells, then registers the
// partial sum, the segment carry-out and the operands that later
// stages still need. Everything advances only when adv_i is high; the
// data registers load only for real operations so bubbles leave the
// last result untouched.
module pipelined_add_sub_stage
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8,
  parameter int IDX       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             valid_i,
  input  logic             carry_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  output logic             valid_o,
  output logic             carry_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o
);

  localparam int LO = IDX * SEG_WIDTH;

  logic [SEG_WIDTH:0]   chain;
  logic [SEG_WIDTH-1:0] seg_sum;
  logic [WIDTH-1:0]     seg_merged;
  logic                 seg_carry;

  logic             valid_q, valid_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;

  // Ripple this segment through the FA cells and splice it into the skewed sum.
  always_comb begin
    chain      = '0;
    seg_sum    = '0;
    chain[0]   = carry_i;
    for (int i = 0; i < SEG_WIDTH; i++) begin
      {chain[i+1], seg_sum[i]} = fa_cell(a_i[LO+i], b_i[LO+i], chain[i]);
    end
    seg_merged                   = sum_i;
    seg_merged[LO +: SEG_WIDTH]  = seg_sum;
    seg_carry                    = chain[SEG_WIDTH];
  end

  // Next-state: valid follows the pipe on advance, data loads only for real ops.
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    if (adv_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        carry_d = seg_carry;
        a_d     = a_i;
        b_d     = b_i;
        sum_d   = seg_merged;
      end
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub for the ALU datapath. The carry
// chain is cut into SEG_WIDTH-bit segments with one register stage per
// segment, so one operation is accepted per clock and its result with
// NZCV flags appears STAGES-1 edges after the accepting edge.
//
// Handshake: a transfer happens on a rising edge where valid && ready
// are both high. The producer holds valid and its data until accepted.
// The whole pipe advances together whenever the output slot is empty
// or being drained (adv), so in_ready is simply adv and result/flags
// stay frozen while out_valid is high and out_ready is low.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int STAGES = WIDTH / SEG_WIDTH;
  localparam int MSB    = WIDTH - 1;

  generate
    if ((WIDTH % SEG_WIDTH) != 0 || STAGES < 1) begin : g_bad_width
      $error("pipelined_add_sub: WIDTH must be a non-zero multiple of SEG_WIDTH");
    end
  endgenerate

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic             valid_w [STAGES+1];
  logic             carry_w [STAGES+1];
  logic [WIDTH-1:0] a_w     [STAGES+1];
  logic [WIDTH-1:0] b_w     [STAGES+1];
  logic [WIDTH-1:0] sum_w   [STAGES+1];

  logic             loaded_q, loaded_d;
  logic [3:0]       flags;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Operand prep: invert b for subtract forms and pick the initial carry.
  always_comb begin
    b_eff = op[0] ? ~b : b;
    c0    = cin;
    case (op_e'(op))
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      default: c0 = cin;
    endcase
  end

  assign valid_w[0] = in_valid;
  assign carry_w[0] = c0;
  assign a_w[0]     = a;
  assign b_w[0]     = b_eff;
  assign sum_w[0]   = '0;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipelined_add_sub_stage #(
        .WIDTH     (WIDTH),
        .SEG_WIDTH (SEG_WIDTH),
        .IDX       (k)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (adv),
        .valid_i (valid_w[k]),
        .carry_i (carry_w[k]),
        .a_i     (a_w[k]),
        .b_i     (b_w[k]),
        .sum_i   (sum_w[k]),
        .valid_o (valid_w[k+1]),
        .carry_o (carry_w[k+1]),
        .a_o     (a_w[k+1]),
        .b_o     (b_w[k+1]),
        .sum_o   (sum_w[k+1])
      );
    end
  endgenerate

  // Z is suppressed until a real result has reached the output, so the
  // flags read all-zero straight out of reset.
  assign loaded_d = loaded_q | (adv & valid_w[STAGES-1]);

  // Remembers that the last stage has held at least one real result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loaded_q <= 1'b0;
    end else begin
      loaded_q <= loaded_d;
    end
  end

  // NZCV from the registered last stage; they move only when result does.
  always_comb begin
    flags         = '0;
    flags[FLAG_N] = sum_w[STAGES][MSB];
    flags[FLAG_Z] = loaded_q && (sum_w[STAGES] == '0);
    flags[FLAG_C] = carry_w[STAGES];
    flags[FLAG_V] = (a_w[STAGES][MSB] == b_w[STAGES][MSB]) &&
                    (sum_w[STAGES][MSB] != a_w[STAGES][MSB]);
  end

  assign out_valid = valid_w[STAGES];
  assign result    = sum_w[STAGES];
  assign flag_n    = flags[FLAG_N];
  assign flag_z    = flags[FLAG_Z];
  assign flag_c    = flags[FLAG_C];
  assign flag_v    = flags[FLAG_V];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub (WIDTH=32, SEG_WIDTH=8): directed
// arithmetic cases, back-pressure, mid-flight reset and a long random
// run against an arithmetic reference model.
module tb_pipelined_add_sub;

  localparam int W = 32;

  // Clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, cin, out_valid, out_ready;
  logic [1:0]   op;
  logic [W-1:0] a, b, result;
  logic         flag_n, flag_z, flag_c, flag_v;

  pipelined_add_sub #(.WIDTH(W), .SEG_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  // Scoreboard: entries are {N, Z, C, V, result}
  logic [W+3:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           drains = 0;
  bit           use_model = 1'b0;
  bit           hold_pending = 1'b0;
  logic [W+3:0] held = '0;
  logic [W+3:0] last_out = '0;
  bit           last_acc, last_ov, last_ir;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic logic [W+3:0] ref_calc(input logic [1:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input logic ci);
    longint ux, uy, sx, sy, lc, s;
    logic   c, v;
    logic [W-1:0] r;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y); lc = ci;
    c = 1'b0; s = 0;
    case (o)
      2'd0: begin s = sx + sy;          c = (ux + uy) >= 64'h1_0000_0000; end
      2'd1: begin s = sx - sy;          c = (ux >= uy); end
      2'd2: begin s = sx + sy + lc;     c = (ux + uy + lc) >= 64'h1_0000_0000; end
      default: begin s = sx - sy - 1 + lc; c = (ux + lc) >= (uy + 1); end
    endcase
    r = s[W-1:0];
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {r[W-1], (r == '0), c, v, r};
  endfunction

  // One clock of stimulus: drive at negedge, check/score just after, then step.
  task automatic cycle(input bit iv, input logic [1:0] iop, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic ic, input bit ordy);
    logic [W+3:0] got, e;
    in_valid = iv; op = iop; a = ia; b = ib; cin = ic; out_ready = ordy;
    #1;
    got      = {flag_n, flag_z, flag_c, flag_v, result};
    last_ov  = out_valid;
    last_ir  = in_ready;
    last_acc = 1'b0;
    if (rst_n) begin
      if (hold_pending) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", got, held);
      end
      chk("in_ready", in_ready, (!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL spurious_out got=%h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          chk("result_flags", got, e);
          drains++;
          last_out = got;
        end
      end
      hold_pending = out_valid && !out_ready;
      held = got;
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        if (use_model) exp_q.push_back(ref_calc(iop, ia, ib, ic));
      end
    end else begin
      hold_pending = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 2'd0, '0, '0, 0, 1);
  endtask

  logic [1:0]   op4[8];
  logic [W-1:0] a4[8], b4[8];
  logic [1:0]   rop;
  logic [W-1:0] ra, rb;
  logic         rc;
  bit           offering;
  int           sent, cyc, d0;
  logic         c_lo;

  initial begin
    rst_n = 1'b0; in_valid = 0; op = 0; a = 0; b = 0; cin = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // 1: SUB 5-3, latency check
    use_model = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 32'd2});
    cycle(1, 2'b01, 32'd5, 32'd3, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 2'd0, '0, '0, 0, 1);
      chk("latency", last_ov, (i == 3));
    end

    // 2: signed overflow and unsigned wrap
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000});
    cycle(1, 2'b00, 32'h7FFF_FFFF, 32'd1, 1, 1);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000});
    cycle(1, 2'b00, 32'hFFFF_FFFF, 32'd1, 0, 1);
    idle(5);
    chk("t2_drained", exp_q.size(), 0);

    // 3: 64-bit add chain through the carry flag
    d0 = drains;
    exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000});
    cycle(1, 2'b00, 32'hFFFF_FFFF, 32'd1, 0, 1);
    for (int i = 0; i < 10 && drains == d0; i++) idle(1);
    chk("t3_lo_done", drains - d0, 1);
    c_lo = last_out[W+1];
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0001});
    cycle(1, 2'b10, 32'd0, 32'd0, c_lo, 1);
    idle(5);
    chk("t3_hi_drained", exp_q.size(), 0);

    // 4: 8 back-to-back ops with a 3-cycle output stall
    use_model = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op4[i] = 2'($urandom_range(0, 3)); a4[i] = $urandom; b4[i] = $urandom;
    end
    d0 = drains; sent = 0; cyc = 0;
    while (sent < 8 && cyc < 40) begin
      cycle(1, op4[sent], a4[sent], b4[sent], 1'($urandom_range(0, 1)),
            !(cyc >= 5 && cyc <= 7));
      if (cyc >= 5 && cyc <= 7) chk("stall_in_ready", last_ir, 0);
      if (last_acc) sent++;
      cyc++;
    end
    chk("b2b_sent", sent, 8);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("b2b_count", drains - d0, 8);

    // 5: reset with three operations in flight
    for (int i = 0; i < 3; i++) cycle(1, 2'b00, $urandom, $urandom, 0, 1);
    rst_n = 1'b0;
    cycle(0, 2'd0, '0, '0, 0, 1);
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 2'd0, '0, '0, 0, 1);
      chk("no_stale", last_ov, 0);
    end

    // 6: random ops with random valid/ready
    d0 = drains; sent = 0; cyc = 0; offering = 1'b0;
    rop = 0; ra = 0; rb = 0; rc = 0;
    while (sent < 10000 && cyc < 60000) begin
      if (!offering) begin
        offering = ($urandom_range(0, 3) != 0);
        rop = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: begin ra = 32'h7FFF_FFFF; rb = $urandom; end
          1: begin ra = $urandom; rb = 32'h8000_0000; end
          2: begin ra = $urandom; rb = ra; end
          default: begin ra = $urandom; rb = $urandom; end
        endcase
        rc = 1'($urandom_range(0, 1));
      end
      cycle(offering, rop, ra, rb, rc, ($urandom_range(0, 3) != 0));
      if (last_acc) begin sent++; offering = 1'b0; end
      cyc++;
    end
    chk("rand_sent", sent, 10000);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("rand_count", drains - d0, 10000);
    chk("rand_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
